// File: rtl/uart_pkg.sv
// Shared UART types, error-bit positions and the oversample tick divider calculation.
// Pure declarations; no logic, no latency.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

  localparam int ERR_BREAK  = 0;
  localparam int ERR_PARITY = 1;
  localparam int ERR_FRAME  = 2;

  // Frame format captured at start detection.
  typedef struct packed {
    logic [3:0] data_bits;
    parity_e    parity;
    logic       stop2;
  } rx_cfg_t;

  function automatic int baud_div(input int sysclk, input int baud, input int os);
    int d;
    d = sysclk / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-cycle tick every DIV clocks; restart realigns the phase.
// Tick is combinational from the counter; no backpressure.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with runtime 5-9 data bits, parity and 1/2 stop bits.
// Frame is presented one cycle after the last stop sample; a held, unaccepted frame causes new frames to be dropped with Rx_Overrun.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int SYSCLK_RATE   = 100000000,
  parameter int BAUD_RATE     = 9600,
  parameter int OVERSAMPLE    = 16,
  parameter int MAX_DATA_BITS = 9
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Rx,
  input  logic [3:0]               Cfg_Data_Bits,
  input  logic [1:0]               Cfg_Parity,
  input  logic                     Cfg_Stop_Bits,
  output logic [MAX_DATA_BITS-1:0] Rx_Data,
  output logic [2:0]               Rx_Err,
  output logic                     Rx_Valid,
  input  logic                     Rx_Ready,
  output logic                     Rx_Overrun,
  output logic                     Rx_Busy
);

  localparam int DIV      = baud_div(SYSCLK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam int MAX_BITS = (MAX_DATA_BITS < 9) ? MAX_DATA_BITS : 9;

  localparam logic [OS_W-1:0] SMP_A   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] SMP_B   = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] SMP_C   = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  function automatic logic [3:0] clamp_bits(input logic [3:0] b);
    if (b < 4'd5) return 4'd5;
    if (b > 4'(MAX_BITS)) return 4'(MAX_BITS);
    return b;
  endfunction

  function automatic parity_e map_parity(input logic [1:0] p);
    case (p)
      2'b01:   return EVEN;
      2'b10:   return ODD;
      default: return NONE;
    endcase
  endfunction

  rx_state_e state, state_next;
  rx_cfg_t   cfg;

  logic                     rx_meta, rx_sync, rx_prev;
  logic                     rx_fall;
  logic                     tick, restart;
  logic [OS_W-1:0]          os_cnt;
  logic                     smp_a, smp_b, voted;
  logic                     active, vote_tick;
  logic [3:0]               bit_cnt;
  logic [MAX_DATA_BITS-1:0] shreg;
  logic                     par_bit, par_err, frame_err, stop_seen;
  logic                     is_break, done, brk;
  logic [2:0]               err_new;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .restart (restart),
    .tick    (tick)
  );

  // Flops preset high so an idle-high line never looks like a start after reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall   = rx_prev & ~rx_sync;
  assign active    = (state != IDLE) && (state != BRK_WAIT);
  assign vote_tick = active && tick && (os_cnt == SMP_C);
  assign voted     = (smp_a & smp_b) | (smp_a & rx_sync) | (smp_b & rx_sync);
  assign is_break  = (shreg == '0) && ((cfg.parity == NONE) || !par_bit) && !voted;
  assign Rx_Busy   = (state != IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    restart    = 1'b0;
    done       = 1'b0;
    brk        = 1'b0;
    case (state)
      IDLE: begin
        if (rx_fall) begin
          state_next = START;
          restart    = 1'b1;
        end
      end
      START: begin
        if (vote_tick) state_next = voted ? IDLE : DATA;
      end
      DATA: begin
        if (vote_tick && (bit_cnt == cfg.data_bits - 4'd1)) begin
          state_next = (cfg.parity == NONE) ? STOP : PARITY;
        end
      end
      PARITY: begin
        if (vote_tick) state_next = STOP;
      end
      STOP: begin
        // A break completes on the first stop sample regardless of stop-bit count.
        if (vote_tick) begin
          if (!stop_seen && is_break) begin
            brk        = 1'b1;
            done       = 1'b1;
            state_next = BRK_WAIT;
          end else if (!stop_seen && cfg.stop2) begin
            state_next = STOP;
          end else begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      BRK_WAIT: begin
        if (rx_sync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    err_new = '0;
    if (brk) begin
      err_new[ERR_BREAK] = 1'b1;
    end else begin
      err_new[ERR_PARITY] = par_err;
      err_new[ERR_FRAME]  = frame_err | ~voted;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cfg       <= '0;
      os_cnt    <= '0;
      smp_a     <= 1'b1;
      smp_b     <= 1'b1;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      stop_seen <= 1'b0;
    end else if (restart) begin
      cfg       <= '{data_bits: clamp_bits(Cfg_Data_Bits),
                     parity:    map_parity(Cfg_Parity),
                     stop2:     Cfg_Stop_Bits};
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      stop_seen <= 1'b0;
    end else if (active && tick) begin
      os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
      if (os_cnt == SMP_A) smp_a <= rx_sync;
      if (os_cnt == SMP_B) smp_b <= rx_sync;
      if (os_cnt == SMP_C) begin
        case (state)
          DATA: begin
            shreg   <= shreg | (MAX_DATA_BITS'(voted) << bit_cnt);
            bit_cnt <= bit_cnt + 4'd1;
          end
          PARITY: begin
            par_bit <= voted;
            par_err <= (^shreg) ^ voted ^ (cfg.parity == ODD);
          end
          STOP: begin
            stop_seen <= 1'b1;
            frame_err <= frame_err | ~voted;
          end
          default: ;
        endcase
      end
    end
  end

  // Output holding register: a held frame wins over a newly completed one.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Rx_Data    <= '0;
      Rx_Err     <= '0;
      Rx_Valid   <= 1'b0;
      Rx_Overrun <= 1'b0;
    end else begin
      Rx_Overrun <= done && Rx_Valid && !Rx_Ready;
      if (done && (!Rx_Valid || Rx_Ready)) begin
        Rx_Valid <= 1'b1;
        Rx_Data  <= brk ? '0 : shreg;
        Rx_Err   <= err_new;
      end else if (Rx_Valid && Rx_Ready) begin
        Rx_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed frames against uart_rx_cfg; expected frames are queued at stimulus time and popped by a transfer monitor.
module tb_uart_rx_cfg;

  localparam int BIT_CLKS = 32;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Rx = 1'b1;
  logic [3:0] Cfg_Data_Bits = 4'd8;
  logic [1:0] Cfg_Parity = 2'b00;
  logic       Cfg_Stop_Bits = 1'b0;
  logic       Rx_Ready = 1'b1;
  logic [8:0] Rx_Data;
  logic [2:0] Rx_Err;
  logic       Rx_Valid;
  logic       Rx_Overrun;
  logic       Rx_Busy;

  uart_rx_cfg #(
    .SYSCLK_RATE   (3200000),
    .BAUD_RATE     (100000),
    .OVERSAMPLE    (16),
    .MAX_DATA_BITS (9)
  ) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Rx            (Rx),
    .Cfg_Data_Bits (Cfg_Data_Bits),
    .Cfg_Parity    (Cfg_Parity),
    .Cfg_Stop_Bits (Cfg_Stop_Bits),
    .Rx_Data       (Rx_Data),
    .Rx_Err        (Rx_Err),
    .Rx_Valid      (Rx_Valid),
    .Rx_Ready      (Rx_Ready),
    .Rx_Overrun    (Rx_Overrun),
    .Rx_Busy       (Rx_Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] data;
    logic [2:0] err;
    int         lat;
    int         t0;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   xfers = 0;
  int   ovr = 0;
  int   rise_cyc = 0;
  logic vld_q = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Transfer monitor: compares every accepted frame against the queue head.
  always @(negedge Clk) begin
    exp_t e;
    if (Rst_n) begin
      if (Rx_Valid && !vld_q) rise_cyc = cyc;
      if (Rx_Overrun) ovr++;
      if (Rx_Valid && Rx_Ready) begin
        xfers++;
        if (sb.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rx_data", int'(Rx_Data), int'(e.data));
          check("rx_err", int'(Rx_Err), int'(e.err));
          if (e.lat >= 0) check("valid_latency", rise_cyc - e.t0, e.lat);
        end
      end
      vld_q = Rx_Valid;
    end
  end

  task automatic tx_bit(input logic b);
    Rx = b;
    repeat (BIT_CLKS) @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic tx_frame(input logic [8:0] d, input int nd, input int pbit,
                          input int nstop, input logic stopv);
    tx_bit(1'b0);
    for (int i = 0; i < nd; i++) tx_bit(d[i]);
    if (pbit >= 0) tx_bit(pbit[0]);
    for (int i = 0; i < nstop; i++) tx_bit(stopv);
  endtask

  task automatic expect_frame(input logic [8:0] d, input logic [2:0] e, input int lat);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.lat  = lat;
    x.t0   = cyc;
    sb.push_back(x);
  endtask

  task automatic set_cfg(input logic [3:0] nb, input logic [1:0] par, input logic st2);
    Cfg_Data_Bits = nb;
    Cfg_Parity    = par;
    Cfg_Stop_Bits = st2;
  endtask

  initial begin
    logic [8:0] d;
    int         x0;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_data", int'(Rx_Data), 0);
    check("reset_err", int'(Rx_Err), 0);
    check("reset_valid", int'(Rx_Valid), 0);
    check("reset_overrun", int'(Rx_Overrun), 0);
    check("reset_busy", int'(Rx_Busy), 0);
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    idle(10);
    check("post_reset_busy", int'(Rx_Busy), 0);

    // 8E1 0xA5: sync(2) + detect(1) + mid-start(20) + 10 bits(320) = 343 clocks to Rx_Valid.
    set_cfg(4'd8, 2'b01, 1'b0);
    expect_frame(9'h0A5, 3'b000, 343);
    d = 9'h0A5;
    tx_bit(1'b0);
    check("busy_mid_frame", int'(Rx_Busy), 1);
    set_cfg(4'd5, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++) tx_bit(d[i]);
    tx_bit(1'b0);
    tx_bit(1'b1);
    idle(20);

    // 8O2 0x55 with a wrong (even) parity bit.
    set_cfg(4'd8, 2'b10, 1'b1);
    expect_frame(9'h055, 3'b010, -1);
    tx_frame(9'h055, 8, 0, 2, 1'b1);
    idle(20);

    // 8N1 0x3C with a low stop bit: frame error, not a break.
    set_cfg(4'd8, 2'b00, 1'b0);
    expect_frame(9'h03C, 3'b100, -1);
    tx_frame(9'h03C, 8, -1, 1, 1'b0);
    idle(40);

    // 8E1 break: line low for 12 bit times, then a normal frame.
    set_cfg(4'd8, 2'b01, 1'b0);
    expect_frame(9'h000, 3'b001, -1);
    Rx = 1'b0;
    repeat (380) @(posedge Clk);
    #1;
    check("break_busy_hold", int'(Rx_Busy), 1);
    repeat (4) @(posedge Clk);
    #1 Rx = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    check("break_busy_release", int'(Rx_Busy), 0);
    idle(20);
    expect_frame(9'h012, 3'b000, -1);
    tx_frame(9'h012, 8, 0, 1, 1'b1);
    idle(20);

    // 6-clock glitch: false start, no frame.
    x0 = xfers;
    Rx = 1'b0;
    repeat (6) @(posedge Clk);
    #1 Rx = 1'b1;
    check("glitch_busy", int'(Rx_Busy), 1);
    repeat (26) @(posedge Clk);
    #1;
    check("glitch_busy_clear", int'(Rx_Busy), 0);
    idle(40);
    check("glitch_no_frame", xfers, x0);

    // 9N1 (out-of-range 12 clamps to 9) with backpressure: second frame is an overrun.
    set_cfg(4'd12, 2'b00, 1'b0);
    Rx_Ready = 1'b0;
    expect_frame(9'h1FF, 3'b000, -1);
    tx_frame(9'h1FF, 9, -1, 1, 1'b1);
    tx_frame(9'h001, 9, -1, 1, 1'b1);
    idle(20);
    check("ovr_valid_held", int'(Rx_Valid), 1);
    check("ovr_data_held", int'(Rx_Data), 9'h1FF);
    check("ovr_pulses", ovr, 1);
    Rx_Ready = 1'b1;
    idle(10);
    check("ovr_valid_cleared", int'(Rx_Valid), 0);

    idle(20);
    check("scoreboard_empty", sb.size(), 0);
    check("transfer_count", xfers, 6);
    check("overrun_total", ovr, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
